branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//   Parametrised dynamic branch predictor: BHT of saturating counters plus tagged BTB.
//   Looks up the fetch PC; the registered result is presented in the decode cycle and drives d_guess_taken.
//   Decode resolves the branch against forwarded rs/rt and trains the table through the update port.
//   Replaces the static not-taken guess.
// PARAMETERS
//   ENTRIES  64  table entries, power of 2; IDX_W = $clog2(ENTRIES)
//   CNT_W    2   saturating counter width, >= 1
//   TAG_W    10  tag bits taken from pc[IDX_W+TAG_W+1 : IDX_W+2]; IDX_W+TAG_W <= 30
//   GHR_W    6   global history length, <= IDX_W; used only with BP_GSHARE_EN
// PORTS
//   clk         in   1   core clock
//   resetn      in   1   asynchronous, active-low reset
//   f_req       in   1   lookup valid this cycle
//   f_pc        in   32  fetch PC to look up
//   p_valid     out  1   prediction valid (registered f_req)
//   p_hit       out  1   valid entry with tag match
//   p_taken     out  1   predict taken (p_hit & counter MSB)
//   p_target    out  32  predicted target (BTB), 0 when !p_hit
//   u_valid     in   1   resolved control-flow instruction in decode
//   u_pc        in   32  PC of resolved instruction
//   u_isbranch  in   1   conditional branch (counter trained only if 1)
//   u_taken     in   1   actual outcome
//   u_target    in   32  actual target
//   flush       in   1   exception/eret redirect: kill pending prediction
// BEHAVIOUR
//   - Index: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
//   - Entry state: {valid, tag, cnt[CNT_W-1:0], target[31:0]}.
//   - Reset (async, resetn=0):
//     - all valid=0; cnt=2^(CNT_W-1)-1 (weakly not-taken); target=0
//     - p_valid, p_hit, p_taken, p_target = 0
//   - Lookup: 1-cycle latency.
//     - Edge with f_req=1: p_* registered from entry[idx(f_pc)].
//     - f_req=0: p_valid=0 and p_hit/p_taken/p_target=0.
//     - flush=1 overrides f_req: p_* = 0 next cycle.
//   - Update (u_valid=1, applied at clock edge):
//     - Entry hit (valid & tag match):
//       - u_isbranch=1: cnt saturating +1 if u_taken, -1 otherwise. Saturates at 2^CNT_W-1 and 0; never wraps.
//       - u_taken=1: target <= u_target.
//       - Jumps (u_isbranch=0): cnt <= max.
//     - Miss and u_taken=1: allocate.
//       - valid=1, tag=tag(u_pc), target=u_target
//       - cnt = 2^(CNT_W-1) (weakly taken), or max for jumps
//     - Miss and u_taken=0: no allocation, no change.
//   - Same-cycle lookup and update to the same idx: lookup returns the pre-update entry (read-before-write).
//   - flush does not cancel a same-cycle update.
//   - resetn low mid-operation: table and outputs cleared immediately; an in-flight update is lost.
// CONFIGURATION
//   `BP_GSHARE_EN defined:
//     - GHR_W-bit global history register (reset 0).
//     - On u_valid & u_isbranch, GHR <= {GHR[GHR_W-2:0], u_taken} (non-speculative).
//     - Lookup and update index = pc[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, GHR}.
//     - Tag unchanged; flush does not touch GHR.
//   Not defined: no GHR logic; index = pc[IDX_W+1:2] only.
// STRUCTURE
//   - cpu_defs.svh: typedef bp_entry_t; typedef bp_req_t {valid, pc}; typedef bp_upd_t {valid, pc, isbranch, taken, target}.
//   - Shared counter-init constant lives there too.
//   - One sub-module: bp_sat_counter (parametrised CNT_W: inc/dec/set_max/set_weak, saturating).
//   - Table is a flop array, required for async clear.
// TESTING
//   - Reset, then lookup f_pc=0xBFC00100 -> p_valid=1, p_hit=0, p_taken=0, p_target=0.
//   - Update u_pc=0xBFC00100 taken, u_target=0xBFC00200 -> next lookup: p_hit=1, p_taken=1, p_target=0xBFC00200 (cnt=2).
//   - Saturation (CNT_W=2), same PC:
//     - 3 more taken updates -> cnt=3.
//     - 1 not-taken -> cnt=2, p_taken=1.
//     - 2nd not-taken -> cnt=1, p_taken=0.
//     - 3 further not-taken -> cnt=0, no wrap.
//   - Alias (ENTRIES=64): train 0xBFC00100, look up 0xBFC01100 (same idx, different tag) -> p_hit=0, p_taken=0.
//   - Same-cycle f_pc=u_pc=0xBFC00100, first taken update -> p_hit=0 that cycle; next lookup -> p_hit=1.
//   - flush with f_req -> p_valid=0.
//   - resetn pulse mid-training -> all lookups miss.
//   - BP_GSHARE_EN: after outcomes T,N,T (GHR=6'b000101), a lookup of 0xBFC00100 uses idx 0x05.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: request/update records, counter ops and init helper.
package branch_predictor_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } bp_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        isbranch;
        logic        taken;
        logic [31:0] target;
    } bp_upd_t;

    typedef enum logic [2:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_SET_MAX,
        CNT_SET_WEAK
    } cnt_op_e;

    // Weakly not-taken: one below the taken threshold.
    function automatic int cnt_weak_nt(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for one saturating counter: inc/dec stop at the rails, set_max, set_weak (weakly taken).
module bp_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  cnt_op_e          op_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    always_comb begin
        cnt_o = cnt_i;
        case (op_i)
            CNT_INC:      if (cnt_i != CNT_MAX) cnt_o = cnt_i + 1'b1;
            CNT_DEC:      if (cnt_i != '0)      cnt_o = cnt_i - 1'b1;
            CNT_SET_MAX:  cnt_o = CNT_MAX;
            CNT_SET_WEAK: cnt_o = CNT_WEAK;
            default:      cnt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// BHT of saturating counters plus tagged BTB, 1-cycle lookup, trained from decode.
// Optional gshare indexing enabled by defining BP_GSHARE_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 10,
    parameter int GHR_W   = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        f_req,
    input  logic [31:0] f_pc,
    output logic        p_valid,
    output logic        p_hit,
    output logic        p_taken,
    output logic [31:0] p_target,
    input  logic        u_valid,
    input  logic [31:0] u_pc,
    input  logic        u_isbranch,
    input  logic        u_taken,
    input  logic [31:0] u_target,
    input  logic        flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_weak_nt(CNT_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [CNT_W-1:0] cnt;
        logic [31:0]      target;
    } bp_entry_t;

    bp_req_t req;
    bp_upd_t upd;
    assign req = '{valid: f_req, pc: f_pc};
    assign upd = '{valid: u_valid, pc: u_pc, isbranch: u_isbranch, taken: u_taken, target: u_target};

    bp_entry_t        tbl_q [ENTRIES];
    logic [IDX_W-1:0] l_idx, u_idx;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    assign ghr_d = (upd.valid && upd.isbranch) ? GHR_W'({ghr_q, upd.taken}) : ghr_q;
    assign l_idx = req.pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign u_idx = upd.pc[IDX_W+1:2] ^ IDX_W'(ghr_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ghr_q <= '0;
        else         ghr_q <= ghr_d;
    end
`else
    assign l_idx = req.pc[IDX_W+1:2];
    assign u_idx = upd.pc[IDX_W+1:2];
`endif

    bp_entry_t        l_ent, u_ent, new_ent;
    logic             l_hit, u_hit, upd_we;
    logic [CNT_W-1:0] cnt_nxt;
    cnt_op_e          cnt_op;

    assign l_ent = tbl_q[l_idx];
    assign u_ent = tbl_q[u_idx];
    assign l_hit = l_ent.valid && (l_ent.tag == req.pc[IDX_W+TAG_W+1:IDX_W+2]);
    assign u_hit = u_ent.valid && (u_ent.tag == upd.pc[IDX_W+TAG_W+1:IDX_W+2]);

    // A miss only allocates on a taken outcome; not-taken misses leave the table alone.
    always_comb begin
        upd_we = 1'b0;
        cnt_op = CNT_HOLD;
        if (upd.valid) begin
            if (u_hit) begin
                upd_we = 1'b1;
                if (upd.isbranch) cnt_op = upd.taken ? CNT_INC : CNT_DEC;
                else              cnt_op = CNT_SET_MAX;
            end else if (upd.taken) begin
                upd_we = 1'b1;
                cnt_op = upd.isbranch ? CNT_SET_WEAK : CNT_SET_MAX;
            end
        end
    end

    bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .op_i  (cnt_op),
        .cnt_i (u_ent.cnt),
        .cnt_o (cnt_nxt)
    );

    always_comb begin
        new_ent       = u_ent;
        new_ent.valid = 1'b1;
        new_ent.tag   = upd.pc[IDX_W+TAG_W+1:IDX_W+2];
        new_ent.cnt   = cnt_nxt;
        if (upd.taken) new_ent.target = upd.target;
    end

    // Flop array so the whole table clears asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl_q[i] <= '{valid: 1'b0, tag: '0, cnt: CNT_INIT, target: '0};
        end else if (upd_we) begin
            tbl_q[u_idx] <= new_ent;
        end
    end

    logic        p_valid_q, p_hit_q, p_taken_q;
    logic [31:0] p_target_q;
    logic        p_valid_d, p_hit_d, p_taken_d;
    logic [31:0] p_target_d;

    always_comb begin
        p_valid_d  = 1'b0;
        p_hit_d    = 1'b0;
        p_taken_d  = 1'b0;
        p_target_d = '0;
        if (req.valid && !flush) begin
            p_valid_d  = 1'b1;
            p_hit_d    = l_hit;
            p_taken_d  = l_hit && l_ent.cnt[CNT_W-1];
            p_target_d = l_hit ? l_ent.target : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_valid_q  <= 1'b0;
            p_hit_q    <= 1'b0;
            p_taken_q  <= 1'b0;
            p_target_q <= '0;
        end else begin
            p_valid_q  <= p_valid_d;
            p_hit_q    <= p_hit_d;
            p_taken_q  <= p_taken_d;
            p_target_q <= p_target_d;
        end
    end

    assign p_valid  = p_valid_q;
    assign p_hit    = p_hit_q;
    assign p_taken  = p_taken_q;
    assign p_target = p_target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + random bench for branch_predictor against an array-based predictor model.
module tb_branch_predictor;

    localparam int ENT   = 64;
    localparam int CMAX  = 3;
    localparam int CTHR  = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        f_req, u_valid, u_isbranch, u_taken, flush;
    logic [31:0] f_pc, u_pc, u_target;
    logic        p_valid, p_hit, p_taken;
    logic [31:0] p_target;

    int checks = 0;
    int errors = 0;

    bit          m_v   [ENT];
    int unsigned m_tag [ENT];
    int          m_cnt [ENT];
    logic [31:0] m_tgt [ENT];
    int unsigned m_ghr;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .resetn(resetn),
        .f_req(f_req), .f_pc(f_pc),
        .p_valid(p_valid), .p_hit(p_hit), .p_taken(p_taken), .p_target(p_target),
        .u_valid(u_valid), .u_pc(u_pc), .u_isbranch(u_isbranch),
        .u_taken(u_taken), .u_target(u_target), .flush(flush)
    );

    function automatic int midx(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
        return int'(((pc >> 2) ^ m_ghr) % ENT);
`else
        return int'((pc >> 2) % ENT);
`endif
    endfunction

    function automatic int unsigned mtag(input logic [31:0] pc);
        return (pc >> 8) % 1024;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENT; i++) begin
            m_v[i] = 1'b0; m_tag[i] = 0; m_cnt[i] = 1; m_tgt[i] = 32'h0;
        end
        m_ghr = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        f_req = 0; f_pc = 0; flush = 0;
        u_valid = 0; u_pc = 0; u_isbranch = 0; u_taken = 0; u_target = 0;
    endtask

    // One clock: predict from the pre-update model, train the model, then compare.
    task automatic cyc(input string tag);
        logic        ev, eh, et;
        logic [31:0] etg;
        int          i;
        ev = 0; eh = 0; et = 0; etg = 0;
        if (f_req && !flush) begin
            i   = midx(f_pc);
            ev  = 1;
            eh  = m_v[i] && (m_tag[i] == mtag(f_pc));
            et  = eh && (m_cnt[i] >= CTHR);
            etg = eh ? m_tgt[i] : 32'h0;
        end
        if (u_valid) begin
            i = midx(u_pc);
            if (m_v[i] && m_tag[i] == mtag(u_pc)) begin
                if (!u_isbranch)  m_cnt[i] = CMAX;
                else if (u_taken) m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                else              m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                if (u_taken) m_tgt[i] = u_target;
            end else if (u_taken) begin
                m_v[i] = 1; m_tag[i] = mtag(u_pc); m_tgt[i] = u_target;
                m_cnt[i] = u_isbranch ? CTHR : CMAX;
            end
            if (u_isbranch) m_ghr = ((m_ghr << 1) | 32'(u_taken)) % 64;
        end
        @(posedge clk); #1;
        chk({tag, ".valid"},  32'(p_valid),  32'(ev));
        chk({tag, ".hit"},    32'(p_hit),    32'(eh));
        chk({tag, ".taken"},  32'(p_taken),  32'(et));
        chk({tag, ".target"}, p_target,      etg);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc);
        set_idle(); f_req = 1; f_pc = pc; cyc(tag);
    endtask

    task automatic update(input string tag, input logic [31:0] pc, input logic br,
                          input logic tk, input logic [31:0] tgt);
        set_idle(); u_valid = 1; u_pc = pc; u_isbranch = br; u_taken = tk; u_target = tgt;
        cyc(tag);
    endtask

    logic [31:0] pool [8];

    initial begin
        pool = '{32'hBFC00100, 32'hBFC01100, 32'hBFC00104, 32'hBFC00200,
                 32'h80000040, 32'h80001040, 32'hBFC003FC, 32'h00000000};
        set_idle();
        model_clear();
        resetn = 0;
        #12;
        chk("rst.valid",  32'(p_valid), 32'h0);
        chk("rst.hit",    32'(p_hit),   32'h0);
        chk("rst.taken",  32'(p_taken), 32'h0);
        chk("rst.target", p_target,     32'h0);
        @(negedge clk); resetn = 1;
        @(posedge clk); #1;

        lookup("cold", 32'hBFC00100);
        update("alloc", 32'hBFC00100, 1, 1, 32'hBFC00200);
        lookup("hit", 32'hBFC00100);
        for (int k = 0; k < 3; k++) update("tk", 32'hBFC00100, 1, 1, 32'hBFC00200);
        lookup("sat3", 32'hBFC00100);
        update("nt1", 32'hBFC00100, 1, 0, 32'h0);
        lookup("cnt2", 32'hBFC00100);
        update("nt2", 32'hBFC00100, 1, 0, 32'h0);
        lookup("cnt1", 32'hBFC00100);
        for (int k = 0; k < 3; k++) update("ntx", 32'hBFC00100, 1, 0, 32'h0);
        lookup("cnt0", 32'hBFC00100);
        update("up1", 32'hBFC00100, 1, 1, 32'hBFC00200);
        lookup("nowrap", 32'hBFC00100);
        lookup("alias", 32'hBFC01100);
        update("jump", 32'hBFC00300, 0, 1, 32'h80000000);
        lookup("jumphit", 32'hBFC00300);

        set_idle(); f_req = 1; f_pc = 32'hBFC00100; flush = 1; cyc("flush");

        // Reset mid-training with an update pending on the inputs.
        set_idle(); u_valid = 1; u_pc = 32'hBFC00104; u_isbranch = 1; u_taken = 1;
        u_target = 32'h1234;
        @(negedge clk); resetn = 0; #1;
        chk("midrst.valid", 32'(p_valid), 32'h0);
        chk("midrst.hit",   32'(p_hit),   32'h0);
        @(posedge clk); @(negedge clk); set_idle(); resetn = 1;
        model_clear();
        @(posedge clk); #1;
        lookup("postrst0", 32'hBFC00100);
        lookup("postrst1", 32'hBFC00300);
        lookup("postrst2", 32'hBFC00104);

        set_idle(); f_req = 1; f_pc = 32'hBFC00100;
        u_valid = 1; u_pc = 32'hBFC00100; u_isbranch = 1; u_taken = 1; u_target = 32'hBFC00200;
        cyc("rbw");
        lookup("rbw.next", 32'hBFC00100);

        for (int n = 0; n < 400; n++) begin
            f_req      = ($urandom_range(0, 3) != 0);
            f_pc       = pool[$urandom_range(0, 7)];
            flush      = ($urandom_range(0, 9) == 0);
            u_valid    = ($urandom_range(0, 1) == 1);
            u_pc       = pool[$urandom_range(0, 7)];
            u_isbranch = ($urandom_range(0, 3) != 0);
            u_taken    = ($urandom_range(0, 1) == 1);
            u_target   = $urandom() & 32'hFFFF_FFFC;
            cyc("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
